r_type_issue: RTL

Issue stage feeding the R-type ALU: accepts RV32I OP-class instruction words from fetch and decodes them. Reads operands from an internal 32x32 register file and blocks read-after-write hazards with a per-register scoreboard. Presents `funct3`, `bit_th`, `in1` and `in2` to the ALU through a registered valid/ready output. The downstream writeback port writes the register file and clears the scoreboard.

---
 rtl/rv_pkg.sv | 38 +++
 rtl/rv_regfile.sv | 63 ++++++
 rtl/r_type_issue.sv | 132 +++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the R-type issue path: opcode/funct constants,
// funct3 operation codes and the R-type instruction field layout.
package rv_pkg;

   localparam logic [6:0] OPC_OP  = 7'b0110011;
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [2:0] {
      F3_ADD  = 3'b000,
      F3_SLL  = 3'b001,
      F3_SLT  = 3'b010,
      F3_SLTU = 3'b011,
      F3_XOR  = 3'b100,
      F3_SR   = 3'b101,
      F3_OR   = 3'b110,
      F3_AND  = 3'b111
   } funct3_e;

   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      logic [6:0] opcode;
   } r_type_t;

   // True for the OP-class words the R-type ALU implements: every funct3 with
   // the base funct7, and only SUB/SRA (funct3 000/101) with the alternate one.
   function automatic logic is_legal_r(input r_type_t w);
      logic alt_ok;
      alt_ok = (w.funct7 == F7_ALT) &&
               ((w.funct3 == F3_ADD) || (w.funct3 == F3_SR));
      return (w.opcode == OPC_OP) && ((w.funct7 == F7_BASE) || alt_ok);
   endfunction

endpackage

// File: rtl/rv_regfile.sv
// Architectural register file: two combinational read ports with
// write-through bypass, one write port, x0 hardwired to zero.
module rv_regfile
   import rv_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   localparam int AW  = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   raddr1,
   output logic [XLEN-1:0] rdata1,
   input  logic [AW-1:0]   raddr2,
   output logic [XLEN-1:0] rdata2,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata
);

   logic [XLEN-1:0] regs [NREG];
   logic            wr_live;

   assign wr_live = we && (waddr != '0);

   // Register storage: synchronous clear, then writes to x1..x31 only.
   // NOTE: register-file arrays are normally left unreset; this one is cleared
   // because software observes all-zero registers after reset.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_live) begin
         regs[waddr] <= wdata;
      end
   end

   // Read port 1: x0 is zero, a same-cycle write to the address forwards.
   always_comb begin
      if (raddr1 == '0) begin
         rdata1 = '0;
      end else if (wr_live && (waddr == raddr1)) begin
         rdata1 = wdata;
      end else begin
         rdata1 = regs[raddr1];
      end
   end

   // Read port 2: same rules as port 1.
   always_comb begin
      if (raddr2 == '0) begin
         rdata2 = '0;
      end else if (wr_live && (waddr == raddr2)) begin
         rdata2 = wdata;
      end else begin
         rdata2 = regs[raddr2];
      end
   end

endmodule

// File: rtl/r_type_issue.sv
// R-type issue stage: decodes OP-class words, reads operands with writeback
// bypass, blocks RAW/WAW hazards with a per-register scoreboard and holds the
// ALU operands in a valid/ready output register.
module r_type_issue
   import rv_pkg::*;
#(
   parameter int XLEN = 32,   // only 32 is supported
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2:0]      funct3,
   output logic            bit_th,
   output logic [XLEN-1:0] in1,
   output logic [XLEN-1:0] in2,
   output logic [4:0]      rd,
   output logic            illegal
);

   r_type_t         word;
   logic            legal;
   logic            hazard;
   logic            slot_free;
   logic            accept;
   logic            issue;
   logic            reject;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic [NREG-1:0] pend_q;
   logic [NREG-1:0] wb_clr;
   logic [NREG-1:0] pend_eff;
   logic [NREG-1:0] pend_set;

   assign word  = r_type_t'(in_instr);
   assign legal = is_legal_r(word);

   rv_regfile #(
      .XLEN (XLEN),
      .NREG (NREG)
   ) u_regfile (
      .clk    (clk),
      .rst    (rst),
      .raddr1 (word.rs1),
      .rdata1 (rs1_val),
      .raddr2 (word.rs2),
      .rdata2 (rs2_val),
      .we     (wb_en),
      .waddr  (wb_rd),
      .wdata  (wb_data)
   );

   // Effective scoreboard: a writeback this cycle already releases its register.
   // NOTE: every combinational output gets a default before any conditional
   // update, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      wb_clr = '0;
      if (wb_en) begin
         wb_clr[wb_rd] = 1'b1;
      end
      pend_eff    = pend_q & ~wb_clr;
      pend_eff[0] = 1'b0;
   end

   // Hazard and handshake: illegal words are always swallowed immediately.
   always_comb begin
      hazard    = legal && (pend_eff[word.rs1] || pend_eff[word.rs2] ||
                            pend_eff[word.rd]);
      slot_free = !out_valid || out_ready;
      if (rst) begin
         in_ready = 1'b0;
      end else if (legal) begin
         in_ready = slot_free && !hazard;
      end else begin
         in_ready = 1'b1;
      end
   end

   assign accept = in_valid && in_ready;
   assign issue  = accept && legal;
   assign reject = accept && !legal;

   // Destination marking for an issued word; x0 is never tracked.
   always_comb begin
      pend_set = '0;
      if (issue && (word.rd != '0)) begin
         pend_set[word.rd] = 1'b1;
      end
   end

   // Scoreboard update: clear from writeback, set from issue; set wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_eff | pend_set;
      end
   end

   // Output register: load on issue, drop valid once consumed, hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         illegal   <= 1'b0;
         funct3    <= '0;
         bit_th    <= 1'b0;
         in1       <= '0;
         in2       <= '0;
         rd        <= '0;
      end else begin
         illegal <= reject;
         if (issue) begin
            out_valid <= 1'b1;
            funct3    <= word.funct3;
            bit_th    <= word.funct7[5];
            in1       <= rs1_val;
            in2       <= rs2_val;
            rd        <= word.rd;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
